disp_scan: RTL and testbench
============================

Name: disp_scan

Overview:
- Downstream stage of the eight-display controller `ctrl`.
- `ctrl` presents per-display segment vectors `a`..`g` and `dp`, 8 bits each, where bit i belongs to display i. This block time-multiplexes them onto one shared cathode bus plus eight anode enables, as on a common multi-digit board.
- Each digit slot is preceded by a blanking gap to suppress ghosting.
- A frame pulse marks each completed 8-digit sweep.

Parameters:
- N_DIG, 8: number of displays (the package constant; fixed at 8 in this revision).
- DIV, 100000: clock cycles a digit is lit per slot; must be ≥1.
- BLANK, 1000: clock cycles all anodes are off before each slot; 0 means no blank phase.
- SEG_INV, 1: 1 means `seg_n`/`dp_n` are driven active-low (input bit 1 = lit gives pin 0); 0 means pins pass through.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- en, in, 1: scan enable; 0 forces all displays dark.
- a, b, c, d, e, f, g, in, 8 each: segment-lit bits per display (bit i = display i), from `ctrl`.
- dp, in, 8: decimal-point-lit bits per display.
- an_n, out, 8: anode enables, active-low; bit i low lights display i.
- seg_n, out, 7: shared cathodes, order {g,f,e,d,c,b,a}, polarity per SEG_INV.
- dp_n, out, 1: shared decimal-point cathode, polarity per SEG_INV.
- idx, out, 3: index of the display currently in its slot (blank or lit).
- frame, out, 1: one-cycle pulse at the end of display 7's lit phase.

Behaviour:
- Reset (asynchronous, while `reset`=0):
  - `an_n`=8'hFF; `seg_n`, `dp_n` at the "all unlit" level (7'h7F / 1 when SEG_INV=1).
  - `idx`=0, `frame`=0, state IDLE, cycle counter = 0.
- All outputs are registered. Reset asserted mid-scan blanks everything asynchronously, with no completion of the current slot.
- States: IDLE, BLANK, ON.
- IDLE:
  - Outputs are dark.
  - If `en`=1 at a clock edge, the next state is BLANK (or ON if BLANK=0) with `idx`=0 and counter = 0.
- BLANK:
  - `an_n`=8'hFF; cathodes at the unlit level.
  - Lasts exactly BLANK cycles, then goes to ON.
- ON:
  - On the edge entering ON, latch {g..a} and `dp` bit `idx` into the cathode register.
  - In the same edge, set `an_n` = ~(1<<`idx`).
  - Inputs that change during ON are ignored until the next slot (no mid-slot glitch).
- ON lasts exactly DIV cycles. On the last ON cycle's edge:
  - `idx` ← (`idx`+1) mod 8; wraps 7→0 with no gap beyond BLANK.
  - Next state is BLANK, or ON with a fresh latch if BLANK=0.
- Per-slot period is BLANK+DIV cycles; frame period is 8×(BLANK+DIV).
- `frame`=1 for exactly the one cycle after the edge that ends the ON phase of `idx`=7; it is 0 otherwise.
- `en` falling in any state: at the next edge go to IDLE, outputs dark, `idx`=0, counter cleared, no `frame` pulse.
- `en` rising restarts the sweep from display 0 with a BLANK phase.
- Counter width: $clog2(max(DIV,BLANK)+1). The counter resets to 0 on every state change and never wraps inside a phase.
- At most one `an_n` bit is low at any time. No cycle exists where a new anode is low while the previous digit's cathodes are still driven.

Decomposition:
- Package `disp_pkg`:
  - N_DIG=8.
  - `typedef logic [6:0] seg_t`, with bit order {g,f,e,d,c,b,a}.
  - `typedef enum logic [1:0] {IDLE, BLANK, ON} scan_state_t`.
  - Constant SEG_OFF=7'h7F.
- One natural sub-module, `scan_timer`: a loadable phase counter that outputs a `done` pulse for a given length (DIV or BLANK).
- `disp_scan` itself holds the FSM, the index, and the latch/mux.

Test Plan (bench uses DIV=4, BLANK=2):
- Reset hold, then release with `en`=1 → `an_n`=8'hFF for 2 cycles, then 8'hFE for 4 cycles, then 8'hFF for 2 cycles, then 8'hFD; `idx` steps 0→1.
- `a`=8'h01, all other inputs 0, SEG_INV=1 → during display 0's slot `seg_n`=7'h7E; during display 1's slot `seg_n`=7'h7F.
- Full sweep → after 48 cycles `frame` pulses once for one cycle, `idx` wraps 7→0, and the next `an_n` lit value is 8'hFE.
- Toggle `dp[3]` from 0 to 1 in the middle of display 3's ON phase → `dp_n` stays 1 for the rest of that slot and goes to 0 in display 3's next slot.
- `en`=0 during display 5's ON phase → the next cycle shows `an_n`=8'hFF and `idx`=0. `en`=1 again → the sweep restarts at display 0 after 2 blank cycles.
- Pull `reset` low asynchronously between edges while a display is lit → `an_n`=8'hFF immediately, without waiting for a clock edge. Also check at every cycle of a 3-frame run that `an_n` never has more than one zero bit.

Source files
------------

// File: rtl/disp_scan_pkg.sv
// Shared types and constants for the eight-digit scan stage.
// Cathode vectors are ordered {g,f,e,d,c,b,a}.
package disp_pkg;

    localparam int N_DIG = 8;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } scan_state_t;

    localparam seg_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/disp_scan_if.sv
// Segment inputs from ctrl and multiplexed
// display pins of the scan stage.
interface disp_scan_if;
    import disp_pkg::*;

    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] f;
    logic [7:0] g;
    logic [7:0] dp;
    logic [7:0] an_n;
    seg_t       seg_n;
    logic       dp_n;
    logic [2:0] idx;
    logic       frame;

    modport master (
        output en, a, b, c, d, e, f, g, dp,
        input  an_n, seg_n, dp_n, idx, frame
    );

    modport slave (
        input  en, a, b, c, d, e, f, g, dp,
        output an_n, seg_n, dp_n, idx, frame
    );

endinterface

// File: rtl/disp_scan_timer.sv
// Phase counter: done flags the last cycle of a
// phase of len_i cycles, then restarts from zero.
module scan_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic [W-1:0] len_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign done_o = (cnt_q == len_i - W'(1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || done_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Eight-digit scan: a blank gap then a lit slot per
// digit, cathodes latched once per slot.
module disp_scan #(
    parameter int DIV     = 100000,
    parameter int BLANK   = 1000,
    parameter bit SEG_INV = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    disp_scan_if.slave  bus
);
    import disp_pkg::*;

    localparam int LMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = $clog2(LMAX + 1);

    localparam seg_t SEG_DARK = SEG_INV ? SEG_OFF : 7'h00;
    localparam logic DP_DARK  = SEG_INV;

    scan_state_t state_q;
    scan_state_t state_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic [7:0]  an_q;
    logic [7:0]  an_d;
    seg_t        seg_q;
    seg_t        seg_d;
    logic        dp_q;
    logic        dp_d;
    logic        frame_q;
    logic        frame_d;
    logic        load;
    logic        dark;
    logic        clr;
    logic        done;
    logic [CW-1:0] len;

    assign len = (state_q == disp_pkg::ON)
               ? CW'(DIV) : CW'(BLANK);
    assign clr = !bus.en || (state_q == disp_pkg::IDLE);

    scan_timer #(
        .W (CW)
    ) u_timer (
        .clk    (clock),
        .rst_n  (reset),
        .clr_i  (clr),
        .len_i  (len),
        .done_o (done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = 1'b0;
        load    = 1'b0;
        dark    = 1'b0;
        if (!bus.en) begin
            state_d = disp_pkg::IDLE;
            idx_d   = '0;
            dark    = 1'b1;
        end else begin
            unique case (state_q)
                disp_pkg::IDLE: begin
                    idx_d = '0;
                    dark  = 1'b1;
                    if (BLANK == 0) begin
                        state_d = disp_pkg::ON;
                        load    = 1'b1;
                    end else begin
                        state_d = disp_pkg::BLANK;
                    end
                end
                disp_pkg::BLANK: begin
                    if (done) begin
                        state_d = disp_pkg::ON;
                        load    = 1'b1;
                    end
                end
                disp_pkg::ON: begin
                    if (done) begin
                        idx_d   = idx_q + 3'd1;
                        frame_d = (idx_q == 3'd7);
                        if (BLANK == 0) begin
                            load = 1'b1;
                        end else begin
                            state_d = disp_pkg::BLANK;
                            dark    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = disp_pkg::IDLE;
                    idx_d   = '0;
                    dark    = 1'b1;
                end
            endcase
        end

        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (dark) begin
            an_d  = 8'hFF;
            seg_d = SEG_DARK;
            dp_d  = DP_DARK;
        end
        // Slot entry: the only point cathodes follow the inputs
        if (load) begin
            an_d  = ~(8'h01 << idx_d);
            seg_d = {bus.g[idx_d], bus.f[idx_d],
                     bus.e[idx_d], bus.d[idx_d],
                     bus.c[idx_d], bus.b[idx_d],
                     bus.a[idx_d]} ^ {7{SEG_INV}};
            dp_d  = bus.dp[idx_d] ^ SEG_INV;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= disp_pkg::IDLE;
            idx_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= SEG_DARK;
            dp_q    <= DP_DARK;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign bus.an_n  = an_q;
    assign bus.seg_n = seg_q;
    assign bus.dp_n  = dp_q;
    assign bus.idx   = idx_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan with DIV=4, BLANK=2,
// active-low cathodes.
module tb_disp_scan;
    import disp_pkg::*;

    localparam int DIV = 4;
    localparam int BLK = 2;
    localparam int P   = DIV + BLK;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
        logic       fr;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    disp_scan_if bus ();

    disp_scan #(
        .DIV     (DIV),
        .BLANK   (BLK),
        .SEG_INV (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_exp = 0;
    int   frames_seen = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // Reference timeline: t counts edges since the
    // sweep started; slot/phase follow from t alone.
    bit         run = 1'b0;
    int         t = 0;
    logic [6:0] lseg = 7'h7F;
    logic       ldp = 1'b1;

    always @(posedge clock) begin
        exp_t       ex;
        int         slot;
        int         ph;
        logic [2:0] s3;
        ex.an  = 8'hFF;
        ex.seg = 7'h7F;
        ex.dp  = 1'b1;
        ex.idx = 3'd0;
        ex.fr  = 1'b0;
        if (!reset || !bus.en) begin
            run = 1'b0;
        end else begin
            if (!run) begin
                run = 1'b1;
                t   = 0;
            end else begin
                t++;
            end
            slot   = (t / P) % 8;
            ph     = t % P;
            s3     = slot[2:0];
            ex.idx = s3;
            if (t > 0 && t % (8 * P) == 0) begin
                ex.fr = 1'b1;
                frames_exp++;
            end
            if (ph >= BLK) begin
                if (ph == BLK) begin
                    lseg = ~{bus.g[s3], bus.f[s3],
                             bus.e[s3], bus.d[s3],
                             bus.c[s3], bus.b[s3],
                             bus.a[s3]};
                    ldp  = ~bus.dp[s3];
                end
                ex.an  = ~(8'h01 << s3);
                ex.seg = lseg;
                ex.dp  = ldp;
            end
        end
        sb.push_back(ex);
    end

    always @(negedge clock) begin
        exp_t ex;
        if (sb.size() > 0) begin
            ex = sb.pop_front();
            chk("an_n",  32'(bus.an_n),  32'(ex.an));
            chk("seg_n", 32'(bus.seg_n), 32'(ex.seg));
            chk("dp_n",  32'(bus.dp_n),  32'(ex.dp));
            chk("idx",   32'(bus.idx),   32'(ex.idx));
            chk("frame", 32'(bus.frame), 32'(ex.fr));
            chk("onehot",
                32'($countones(~bus.an_n) <= 1), 32'd1);
            if (bus.frame) frames_seen++;
        end
    end

    task automatic wait_lit(input int k);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(negedge clock);
            n++;
            hit = (32'(bus.idx) == k) && (bus.an_n != 8'hFF);
        end
        if (!hit) chk("lit_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.a  = 8'h01;
        bus.b  = 8'h00;
        bus.c  = 8'h00;
        bus.d  = 8'h00;
        bus.e  = 8'h00;
        bus.f  = 8'h00;
        bus.g  = 8'h00;
        bus.dp = 8'h00;
        #1 reset = 1'b0;
        #1;
        chk("rst_an",    32'(bus.an_n),  32'hFF);
        chk("rst_seg",   32'(bus.seg_n), 32'h7F);
        chk("rst_dp",    32'(bus.dp_n),  32'd1);
        chk("rst_idx",   32'(bus.idx),   32'd0);
        chk("rst_frame", 32'(bus.frame), 32'd0);
        repeat (3) @(negedge clock);
        #2;
        bus.en = 1'b1;
        reset  = 1'b1;

        wait_lit(0);
        chk("seg_d0", 32'(bus.seg_n), 32'h7E);
        wait_lit(1);
        chk("seg_d1", 32'(bus.seg_n), 32'h7F);

        wait_lit(3);
        @(negedge clock);
        #2 bus.dp = 8'h08;
        @(negedge clock);
        chk("dp_hold", 32'(bus.dp_n), 32'd1);
        wait_lit(4);
        wait_lit(3);
        chk("dp_next", 32'(bus.dp_n), 32'd0);
        #2 bus.dp = 8'h00;

        wait_lit(5);
        #2 bus.en = 1'b0;
        @(negedge clock);
        chk("en_off_an",  32'(bus.an_n), 32'hFF);
        chk("en_off_idx", 32'(bus.idx),  32'd0);
        repeat (2) @(negedge clock);
        #2 bus.en = 1'b1;
        repeat (3) @(negedge clock);
        chk("restart_an", 32'(bus.an_n), 32'hFE);

        for (int i = 0; i < 3 * 8 * P; i++) begin
            @(negedge clock);
            if (i % 7 == 3) begin
                #2;
                bus.a  = 8'($urandom);
                bus.b  = 8'($urandom);
                bus.c  = 8'($urandom);
                bus.d  = 8'($urandom);
                bus.e  = 8'($urandom);
                bus.f  = 8'($urandom);
                bus.g  = 8'($urandom);
                bus.dp = 8'($urandom);
            end
        end

        wait_lit(2);
        #2 reset = 1'b0;
        #1;
        chk("async_an",  32'(bus.an_n),  32'hFF);
        chk("async_seg", 32'(bus.seg_n), 32'h7F);
        chk("async_idx", 32'(bus.idx),   32'd0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        repeat (2 * P) @(negedge clock);

        chk("frames", 32'(frames_seen), 32'(frames_exp));
        chk("frames_nz", 32'(frames_exp >= 3), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
